// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
package regfile_pkg;

    localparam int W_DEF        = 32;
    localparam int AW_DEF       = 5;
    localparam bit ZERO_REG_DEF = 1'b1;
    localparam bit BYPASS_DEF   = 1'b1;

    // Number of architectural registers addressable with an aw-bit index.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int DEPTH_DEF = depth_of(AW_DEF);

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-producer tracking: one busy bit per register, issue stall and
// operand-ready generation for both read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int AW       = AW_DEF,
    parameter  bit ZERO_REG = ZERO_REG_DEF,
    parameter  bit BYPASS   = BYPASS_DEF,
    localparam int DEPTH    = depth_of(AW)
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic [AW-1:0]    Ard1,
    input  logic [AW-1:0]    Ard2,
    input  logic [AW-1:0]    Awr,
    input  logic             WrEn,
    input  logic [AW-1:0]    IssAddr,
    input  logic             IssEn,
    output logic             Rdy1,
    output logic             Rdy2,
    output logic             IssStall,
    output logic [DEPTH-1:0] BusyVec
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic             iss_set;

    // Issue is rejected only while the destination has an outstanding
    // producer that is not retiring this very cycle; a writeback to the
    // same register lets the new issue replace the old producer.
    always_comb begin
        IssStall = RstN && IssEn && busy_q[IssAddr] && !(WrEn && (Awr == IssAddr));
        iss_set  = IssEn && !IssStall && !(ZERO_REG && (IssAddr == '0));
    end

    // Writeback clears first so that a same-cycle issue to that register wins.
    always_comb begin
        busy_d = busy_q;
        if (WrEn)    busy_d[Awr]     = 1'b0;
        if (iss_set) busy_d[IssAddr] = 1'b1;
    end

    // Busy bits; reset discards any concurrent issue or writeback.
    always_ff @(posedge Clk) begin
        if (!RstN) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // Operand ready: no pending producer, or it is being written back now
    // and that data is forwarded. Register 0 under ZERO_REG is never busy.
    always_comb begin
        Rdy1 = !RstN || !busy_q[Ard1] || (BYPASS && WrEn && (Awr == Ard1))
               || (ZERO_REG && (Ard1 == '0));
        Rdy2 = !RstN || !busy_q[Ard2] || (BYPASS && WrEn && (Awr == Ard2))
               || (ZERO_REG && (Ard2 == '0));
    end

    assign BusyVec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with optional write-to-read bypass and
// a busy-bit scoreboard for in-flight producers.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int W        = W_DEF,
    parameter  int AW       = AW_DEF,
    parameter  bit ZERO_REG = ZERO_REG_DEF,
    parameter  bit BYPASS   = BYPASS_DEF,
    localparam int DEPTH    = depth_of(AW)
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic [AW-1:0]    Ard1,
    input  logic [AW-1:0]    Ard2,
    output logic [W-1:0]     Dout1,
    output logic [W-1:0]     Dout2,
    output logic             Rdy1,
    output logic             Rdy2,
    input  logic [AW-1:0]    Awr,
    input  logic [W-1:0]     Din,
    input  logic             WrEn,
    input  logic [AW-1:0]    IssAddr,
    input  logic             IssEn,
    output logic             IssStall,
    output logic [DEPTH-1:0] BusyVec
);

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

    // Next array contents; writes to the hardwired-zero register are dropped.
    always_comb begin
        mem_d = mem_q;
        if (WrEn && !(ZERO_REG && (Awr == '0))) mem_d[Awr] = Din;
    end

    // Data array storage with synchronous clear.
    always_ff @(posedge Clk) begin
        if (!RstN) mem_q <= '0;
        else       mem_q <= mem_d;
    end

    // Combinational reads with optional forwarding of the in-flight write.
    // Outputs are forced to zero while reset is asserted.
    always_comb begin
        Dout1 = mem_q[Ard1];
        if (BYPASS && WrEn && (Awr == Ard1))        Dout1 = Din;
        if (!RstN || (ZERO_REG && (Ard1 == '0)))    Dout1 = '0;
        Dout2 = mem_q[Ard2];
        if (BYPASS && WrEn && (Awr == Ard2))        Dout2 = Din;
        if (!RstN || (ZERO_REG && (Ard2 == '0)))    Dout2 = '0;
    end

    regfile_scoreboard #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .Clk      (Clk),
        .RstN     (RstN),
        .Ard1     (Ard1),
        .Ard2     (Ard2),
        .Awr      (Awr),
        .WrEn     (WrEn),
        .IssAddr  (IssAddr),
        .IssEn    (IssEn),
        .Rdy1     (Rdy1),
        .Rdy2     (Rdy2),
        .IssStall (IssStall),
        .BusyVec  (BusyVec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboarded register file bench: two DUTs (bypass on / off) share the
// stimulus; a reference model produces expected outputs into a queue and a
// monitor pops and compares every cycle.
module tb_regfile_sb;

    localparam int W     = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic             Clk = 1'b0;
    logic             RstN;
    logic [AW-1:0]    Ard1, Ard2, Awr, IssAddr;
    logic [W-1:0]     Din;
    logic             WrEn, IssEn;

    logic [W-1:0]     d1a, d2a, d1b, d2b;
    logic             r1a, r2a, r1b, r2b, sa, sb;
    logic [DEPTH-1:0] bva, bvb;

    always #5 Clk = ~Clk;

    regfile_sb #(.W(W), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .Clk(Clk), .RstN(RstN), .Ard1(Ard1), .Ard2(Ard2), .Dout1(d1a), .Dout2(d2a),
        .Rdy1(r1a), .Rdy2(r2a), .Awr(Awr), .Din(Din), .WrEn(WrEn),
        .IssAddr(IssAddr), .IssEn(IssEn), .IssStall(sa), .BusyVec(bva));

    regfile_sb #(.W(W), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .Clk(Clk), .RstN(RstN), .Ard1(Ard1), .Ard2(Ard2), .Dout1(d1b), .Dout2(d2b),
        .Rdy1(r1b), .Rdy2(r2b), .Awr(Awr), .Din(Din), .WrEn(WrEn),
        .IssAddr(IssAddr), .IssEn(IssEn), .IssStall(sb), .BusyVec(bvb));

    typedef struct {
        logic [W-1:0]     d1a, d2a, d1b, d2b;
        logic             r1a, r2a, r1b, r2b, stall;
        logic [DEPTH-1:0] bv;
    } exp_t;

    exp_t q[$];

    // Reference state: architectural contents and outstanding producers.
    logic [W-1:0] mem [DEPTH];
    bit           busy[DEPTH];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] m_rd(input logic [AW-1:0] a, input bit byp, input bit rn,
                                          input bit we, input logic [AW-1:0] aw,
                                          input logic [W-1:0] d);
        if (!rn || a == 0)           return '0;
        if (byp && we && aw == a)    return d;
        return mem[a];
    endfunction

    function automatic logic m_rdy(input logic [AW-1:0] a, input bit byp, input bit rn,
                                   input bit we, input logic [AW-1:0] aw);
        if (!rn || a == 0) return 1'b1;
        return !busy[a] || (byp && we && aw == a);
    endfunction

    // One cycle of stimulus: drive, predict outputs, then advance the model.
    task automatic step(input bit rn, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input bit we, input logic [AW-1:0] aw, input logic [W-1:0] d,
                        input bit iss, input logic [AW-1:0] ia);
        exp_t e;
        bit   stall;
        @(posedge Clk); #1;
        RstN = rn; Ard1 = a1; Ard2 = a2; WrEn = we; Awr = aw; Din = d;
        IssEn = iss; IssAddr = ia;
        stall   = rn && iss && busy[ia] && !(we && aw == ia);
        e.d1a   = m_rd(a1, 1, rn, we, aw, d);
        e.d2a   = m_rd(a2, 1, rn, we, aw, d);
        e.d1b   = m_rd(a1, 0, rn, we, aw, d);
        e.d2b   = m_rd(a2, 0, rn, we, aw, d);
        e.r1a   = m_rdy(a1, 1, rn, we, aw);
        e.r2a   = m_rdy(a2, 1, rn, we, aw);
        e.r1b   = m_rdy(a1, 0, rn, we, aw);
        e.r2b   = m_rdy(a2, 0, rn, we, aw);
        e.stall = stall;
        for (int i = 0; i < DEPTH; i++) e.bv[i] = busy[i];
        q.push_back(e);
        if (!rn) begin
            for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; busy[i] = 0; end
        end else begin
            if (we && aw != 0)               mem[aw] = d;
            if (we)                          busy[aw] = 0;
            if (iss && !stall && ia != 0)    busy[ia] = 1;
        end
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the oldest prediction.
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("dout1_byp",  d1a, e.d1a);
            chk("dout2_byp",  d2a, e.d2a);
            chk("dout1_nobyp", d1b, e.d1b);
            chk("dout2_nobyp", d2b, e.d2b);
            chk("rdy1_byp",   W'(r1a), W'(e.r1a));
            chk("rdy2_byp",   W'(r2a), W'(e.r2a));
            chk("rdy1_nobyp", W'(r1b), W'(e.r1b));
            chk("rdy2_nobyp", W'(r2b), W'(e.r2b));
            chk("stall_byp",  W'(sa),  W'(e.stall));
            chk("stall_nobyp", W'(sb), W'(e.stall));
            chk("busyvec_byp",  bva, e.bv);
            chk("busyvec_nobyp", bvb, e.bv);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a1, a2, aw, ia;
        for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; busy[i] = 0; end
        RstN = 1'b0; Ard1 = '0; Ard2 = '0; Awr = '0; Din = '0; WrEn = 1'b0;
        IssEn = 1'b0; IssAddr = '0;

        // Reset, then sweep every address on both ports.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, AW'(i), AW'(DEPTH-1-i), 0, 0, 0, 0, 0);

        // Same-cycle write/read of register 5.
        step(1, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        step(1, 5, 5, 0, 0, 0, 0, 0);

        // Register 0 is hardwired: write and issue both ignored.
        step(1, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // Issue 7, stalled re-issue, writeback clears.
        step(1, 7, 0, 0, 0, 0, 1, 7);
        step(1, 7, 0, 0, 0, 0, 1, 7);
        step(1, 7, 7, 1, 7, 32'h12, 0, 0);
        step(1, 7, 0, 0, 0, 0, 0, 0);

        // Re-issue 9 while its writeback retires: set wins.
        step(1, 9, 0, 0, 0, 0, 1, 9);
        step(1, 9, 0, 1, 9, 32'hCAFE0009, 1, 9);
        step(1, 9, 0, 0, 0, 0, 1, 9);
        step(1, 9, 0, 1, 9, 32'h9999, 0, 0);

        // Reset overrides concurrent write and issue.
        step(1, 3, 0, 1, 3, 32'h55, 0, 0);
        step(0, 3, 3, 1, 3, 32'h77, 1, 3);
        step(1, 3, 3, 0, 0, 0, 0, 0);

        // Random traffic concentrated on a few registers for collisions.
        for (int n = 0; n < 1500; n++) begin
            a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            aw = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            ia = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            step(($urandom_range(0, 199) != 0), a1, a2, $urandom_range(0, 1) == 1, aw,
                 $urandom, $urandom_range(0, 1) == 1, ia);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge Clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter W, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; DEPTH = 2**AW registers.
REQ-003 Parameter ZERO_REG, default 1, register 0 reads as zero and ignores writes when 1.
REQ-004 Parameter BYPASS, default 1, same-cycle write data forwarded to read ports when 1.
REQ-005 The block SHALL use one clock, Clk, and a synchronous, active-low reset, RstN, and SHALL have these ports:
- Clk  in  1  rising-edge clock.
- RstN  in  1  synchronous, active-low reset.
- Ard1  in  AW  read address, port 1.
- Ard2  in  AW  read address, port 2.
- Dout1  out  W  read data, port 1.
- Dout2  out  W  read data, port 2.
- Rdy1  out  1  port-1 operand valid (no pending producer).
- Rdy2  out  1  port-2 operand valid.
- Awr  in  AW  write/writeback address.
- Din  in  W  write data.
- WrEn  in  1  write enable.
- IssAddr  in  AW  destination of issuing instruction.
- IssEn  in  1  issue request, marks IssAddr pending.
- IssStall  out  1  issue rejected this cycle.
- BusyVec  out  DEPTH  pending bit per register.

Function
REQ-006 Reads SHALL be combinational: Dout1 = reg[Ard1] and Dout2 = reg[Ard2], zero latency.
REQ-007 Write: when WrEn=1, reg[Awr] <= Din at the rising edge of Clk; write visible to reads the next cycle.
REQ-008 When ZERO_REG=1: reads of address 0 return 0; writes to 0 are discarded; 0 is never busy.
REQ-009 When BYPASS=1, WrEn=1 and Awr=ArdN (excluding address 0 under ZERO_REG), DoutN SHALL equal Din in the same cycle.
REQ-010 When BYPASS=0, a same-cycle read SHALL return the old contents.
REQ-011 Busy set: at the edge, busy[IssAddr] <= 1 when IssEn=1 and IssStall=0 (excluding address 0 under ZERO_REG).
REQ-012 Busy clear: at the edge, busy[Awr] <= 0 when WrEn=1, unless it is set by REQ-011 in the same cycle.
REQ-013 Simultaneous set and clear of the same address: set wins; busy stays 1 and the new producer is recorded.
REQ-014 IssStall = IssEn & busy[IssAddr] & !(WrEn & Awr=IssAddr); a stalled issue changes no state.
REQ-015 RdyN = !busy[ArdN] | (BYPASS & WrEn & Awr=ArdN); address 0 under ZERO_REG is always ready.
REQ-016 A write to a non-busy register is legal: data is updated and busy stays 0.
REQ-017 BusyVec SHALL equal the registered busy bits, with no combinational path from inputs.

Reset
REQ-018 When RstN=0 at a rising edge, all DEPTH registers SHALL be cleared to 0 and all busy bits cleared to 0.
REQ-019 Reset SHALL take priority over WrEn and IssEn in the same cycle; those requests are discarded.
REQ-020 During and after reset, Dout1=Dout2=0, Rdy1=Rdy2=1, IssStall=0 and BusyVec=0 until the next write or issue.

Structure
REQ-021 Package regfile_pkg SHALL hold the W, AW, ZERO_REG and BYPASS defaults and the DEPTH derivation.
REQ-022 One sub-module, regfile_scoreboard, SHALL hold the busy bits, IssStall and Rdy logic; the data array and bypass stay in regfile_sb.

Verification
REQ-023 Reset, then read all addresses -> Dout=0, Rdy=1, BusyVec=0.
REQ-024 Write Awr=5, Din=0xDEADBEEF with Ard1=5 same cycle (BYPASS=1) -> Dout1=0xDEADBEEF that cycle and after; with BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next.
REQ-025 Write Awr=0, Din=0xFFFFFFFF (ZERO_REG=1) -> Dout=0 at Ard=0; IssEn to address 0 -> BusyVec unchanged.
REQ-026 Issue 7 -> BusyVec[7]=1, Rdy1=0 at Ard1=7; re-issue 7 -> IssStall=1; write 7 with Din=0x12 -> Rdy1=1 same cycle, busy[7]=0 next cycle.
REQ-027 Issue 9 with WrEn Awr=9 same cycle while busy[9]=1 -> IssStall=0, busy[9] stays 1, reg[9]=Din.
REQ-028 RstN=0 with WrEn=1 Awr=3 and IssEn=1 IssAddr=3 -> reg[3]=0, busy[3]=0.
